acc_datapath_ext: RTL and testbench

Parametrised accumulator datapath for the BIP-style processor: it sign-extends the instruction operand, selects ACC sources, and runs an 8-operation ALU with status flags. It adds a multi-cycle unsigned multiplier with a Busy/Done handshake toward the control unit. It sits between the control unit (SelA, SelB, WrAcc, Op), the data memory (Out_Data, In_Data, Addr_DM) and the instruction operand field (Addr).

---
 rtl/acc_datapath_pkg.sv | 29 ++
 rtl/seq_multiplier.sv | 71 +++++++
 rtl/acc_datapath_ext.sv | 143 ++++++++++++++
 tb/tb_acc_datapath_ext.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/acc_datapath_pkg.sv
// acc_datapath_pkg: shared constants and types for the accumulator datapath.
//   - ALU op-code encodings (OP_ADD .. OP_MUL)
//   - ACC source select encodings (SELA_*)
//   - multiplier FSM state type and status flag bundle
package acc_datapath_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] SELA_ALU = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_MEM = 2'd2;

  typedef enum logic {ST_IDLE, ST_MUL} mul_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one multiplier bit per cycle.
//   clk, Clear    : clock, async active-high reset (aborts a running multiply)
//   start         : accept a new multiply (ignored unless idle)
//   a, b          : multiplicand / multiplier, latched on accept
//   busy          : multiply in progress
//   done          : this cycle is the final iteration; product is final now
//   product       : running product including the current iteration's add,
//                   so the final value is available combinationally in the
//                   done cycle and the owner can capture it on that edge
module seq_multiplier
  import acc_datapath_pkg::*;
#(
  parameter int DB = 16
) (
  input  logic            clk,
  input  logic            Clear,
  input  logic            start,
  input  logic [DB-1:0]   a,
  input  logic [DB-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*DB-1:0] product
);

  localparam int CW = $clog2(DB);

  mul_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [2*DB-1:0] mcand_q;   // pre-shifted multiplicand, moves left each step
  logic [2*DB-1:0] prod_q;
  logic [DB-1:0]   mplier_q;  // moves right each step; bit 0 is current bit

  assign busy    = (state_q == ST_MUL);
  assign done    = busy && (cnt_q == CW'(DB-1));
  assign product = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mcand_q  <= {{DB{1'b0}}, a};
            mplier_q <= b;
            prod_q   <= '0;
            cnt_q    <= '0;
            state_q  <= ST_MUL;
          end
        end
        ST_MUL: begin
          prod_q   <= product;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (done) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/acc_datapath_ext.sv
// acc_datapath_ext: accumulator datapath with 8-op ALU, status flags and a
// multi-cycle unsigned multiplier.
//   clk, Clear        : clock, async active-high reset
//   SelA              : ACC source (ALU / sext(Addr) / Out_Data / 3 = no write)
//   SelB              : ALU operand B (sext(Addr) / Out_Data)
//   WrAcc, Op         : write request and ALU op (MUL runs multi-cycle)
//   Out_Data, Addr    : memory read data, instruction operand
//   In_Data, Addr_DM  : memory write data (= ACC), memory address (= Addr)
//   Busy, Done        : multiply in progress, one-cycle completion pulse
//   Z, N, C, V        : status flags, updated on every ACC write
module acc_datapath_ext
  import acc_datapath_pkg::*;
#(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          Clear,
  input  logic [1:0]    SelA,
  input  logic          SelB,
  input  logic          WrAcc,
  input  logic [2:0]    Op,
  input  logic [DB-1:0] Out_Data,
  input  logic [AB-1:0] Addr,
  output logic [DB-1:0] In_Data,
  output logic [AB-1:0] Addr_DM,
  output logic          Busy,
  output logic          Done,
  output logic          Z,
  output logic          N,
  output logic          C,
  output logic          V
);

  localparam int SH = $clog2(DB);

  logic [DB-1:0]   acc_q, acc_d;
  flags_t          flg_q, flg_d;
  logic            done_q;

  logic [DB-1:0]   imm, b_op, b_eff, alu_res;
  logic [DB:0]     sum;
  logic            alu_c, alu_v;
  logic            wr_single, mul_start;
  logic            mul_busy, mul_done;
  logic [2*DB-1:0] mul_prod;

  assign imm     = DB'($signed(Addr));
  assign b_op    = SelB ? Out_Data : imm;
  assign Addr_DM = Addr;

  // SUB is A + ~B + 1, so C is the no-borrow indication.
  assign b_eff = (Op == OP_SUB) ? ~b_op : b_op;
  assign sum   = {1'b0, acc_q} + {1'b0, b_eff} + {{DB{1'b0}}, (Op == OP_SUB)};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (Op)
      OP_ADD, OP_SUB: begin
        alu_res = sum[DB-1:0];
        alu_c   = sum[DB];
        alu_v   = (acc_q[DB-1] == b_eff[DB-1]) && (sum[DB-1] != acc_q[DB-1]);
      end
      OP_AND:  alu_res = acc_q & b_op;
      OP_OR:   alu_res = acc_q | b_op;
      OP_XOR:  alu_res = acc_q ^ b_op;
      OP_SLL:  alu_res = acc_q << b_op[SH-1:0];
      OP_SRA:  alu_res = DB'($signed(acc_q) >>> b_op[SH-1:0]);
      default: alu_res = '0;
    endcase
  end

  // WrAcc is dropped outright while the multiplier runs.
  assign mul_start = WrAcc && !mul_busy && (SelA == SELA_ALU) && (Op == OP_MUL);
  assign wr_single = WrAcc && !mul_busy && (SelA != 2'd3) &&
                     !((SelA == SELA_ALU) && (Op == OP_MUL));

  seq_multiplier #(.DB(DB)) u_mul (
    .clk     (clk),
    .Clear   (Clear),
    .start   (mul_start),
    .a       (acc_q),
    .b       (b_op),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    acc_d = acc_q;
    flg_d = flg_q;
    if (mul_done) begin
      acc_d   = mul_prod[DB-1:0];
      flg_d.c = |mul_prod[2*DB-1:DB];
      flg_d.v = 1'b0;
    end else if (wr_single) begin
      case (SelA)
        SELA_ALU: begin
          acc_d   = alu_res;
          flg_d.c = alu_c;
          flg_d.v = alu_v;
        end
        SELA_IMM: begin
          acc_d   = imm;
          flg_d.c = 1'b0;
          flg_d.v = 1'b0;
        end
        default: begin
          acc_d   = Out_Data;
          flg_d.c = 1'b0;
          flg_d.v = 1'b0;
        end
      endcase
    end
    if (mul_done || wr_single) begin
      flg_d.z = (acc_d == '0);
      flg_d.n = acc_d[DB-1];
    end
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      acc_q  <= '0;
      flg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      flg_q  <= flg_d;
      done_q <= mul_done;
    end
  end

  assign In_Data = acc_q;
  assign Busy    = mul_busy;
  assign Done    = done_q;
  assign Z       = flg_q.z;
  assign N       = flg_q.n;
  assign C       = flg_q.c;
  assign V       = flg_q.v;

endmodule

// File: tb/tb_acc_datapath_ext.sv
module tb_acc_datapath_ext;

  logic        clk;
  logic        Clear;
  logic [1:0]  SelA;
  logic        SelB;
  logic        WrAcc;
  logic [2:0]  Op;
  logic [15:0] Out_Data;
  logic [10:0] Addr;
  logic [15:0] In_Data;
  logic [10:0] Addr_DM;
  logic        Busy, Done, Z, N, C, V;

  int n_cmp = 0;
  int n_err = 0;

  acc_datapath_ext #(.AB(11), .DB(16)) dut (
    .clk(clk), .Clear(Clear), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc),
    .Op(Op), .Out_Data(Out_Data), .Addr(Addr), .In_Data(In_Data),
    .Addr_DM(Addr_DM), .Busy(Busy), .Done(Done), .Z(Z), .N(N), .C(C), .V(V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {Z,N,C,V}
  task automatic chk_state(input string tag, input logic [15:0] acc, input logic [3:0] f);
    chk({tag, "_acc"}, {16'h0, In_Data}, {16'h0, acc});
    chk({tag, "_flags"}, {28'h0, Z, N, C, V}, {28'h0, f});
  endtask

  // Apply one write request for one edge, then deassert WrAcc.
  task automatic wr(input logic [1:0] sa, input logic sb, input logic [2:0] op,
                    input logic [10:0] ad, input logic [15:0] od);
    SelA = sa; SelB = sb; Op = op; Addr = ad; Out_Data = od; WrAcc = 1'b1;
    @(posedge clk); #1;
    WrAcc = 1'b0;
  endtask

  initial begin
    int cyc;
    int done_seen;
    Clear = 1'b1; SelA = 2'd0; SelB = 1'b0; WrAcc = 1'b0; Op = 3'd0;
    Out_Data = 16'h0; Addr = 11'h0;
    @(posedge clk); #1;
    chk_state("reset", 16'h0000, 4'b0000);
    chk("reset_busy", {31'h0, Busy}, 32'h0);
    chk("reset_done", {31'h0, Done}, 32'h0);
    Clear = 1'b0;
    @(posedge clk); #1;

    // Sign-extended immediate load
    wr(2'd1, 1'b0, 3'd0, 11'h7FF, 16'h0);
    chk_state("ld_imm_neg", 16'hFFFF, 4'b0100);
    Addr = 11'h2A5; #1;
    chk("addr_dm", {21'h0, Addr_DM}, {21'h0, 11'h2A5});

    // 7FFF + 1 overflow
    wr(2'd2, 1'b0, 3'd0, 11'h0, 16'h7FFF);
    chk_state("ld_mem", 16'h7FFF, 4'b0000);
    wr(2'd0, 1'b0, 3'd0, 11'h001, 16'h0);
    chk_state("add_ovf", 16'h8000, 4'b0101);

    // 5 - 5: zero, no borrow
    wr(2'd1, 1'b0, 3'd0, 11'h005, 16'h0);
    wr(2'd0, 1'b1, 3'd1, 11'h0, 16'h0005);
    chk_state("sub_zero", 16'h0000, 4'b1010);
    wr(2'd0, 1'b1, 3'd4, 11'h0, 16'h00FF);
    chk_state("xor", 16'h00FF, 4'b0000);

    // SelA=3 holds ACC and flags
    wr(2'd3, 1'b1, 3'd0, 11'h0, 16'h1234);
    chk_state("sela3_hold", 16'h00FF, 4'b0000);

    // Shifts
    wr(2'd0, 1'b0, 3'd5, 11'h004, 16'h0);
    chk_state("sll4", 16'h0FF0, 4'b0000);
    wr(2'd1, 1'b0, 3'd0, 11'h400, 16'h0);
    chk_state("ld_fc00", 16'hFC00, 4'b0100);
    wr(2'd0, 1'b0, 3'd6, 11'h002, 16'h0);
    chk_state("sra2", 16'hFF00, 4'b0100);
    wr(2'd0, 1'b1, 3'd2, 11'h0, 16'h0F0F);
    chk_state("and", 16'h0F00, 4'b0000);

    // 300 * 300 = 0x15F90, with a stray write mid-multiply
    wr(2'd1, 1'b0, 3'd0, 11'h12C, 16'h0);
    wr(2'd0, 1'b1, 3'd7, 11'h0, 16'd300);
    cyc = 0; done_seen = 0;
    while (Busy && cyc < 40) begin
      if (Done) done_seen++;
      if (cyc == 3) begin SelA = 2'd1; Addr = 11'h005; WrAcc = 1'b1; end
      else WrAcc = 1'b0;
      if (cyc == 5) chk("mul_acc_held", {16'h0, In_Data}, {16'h0, 16'h012C});
      cyc++;
      @(posedge clk); #1;
    end
    WrAcc = 1'b0;
    chk("mul_busy_cycles", cyc, 16);
    chk("mul_no_early_done", done_seen, 0);
    chk("mul_done_pulse", {31'h0, Done}, 32'h1);
    chk_state("mul_300", 16'h5F90, 4'b0010);
    @(posedge clk); #1;
    chk("mul_done_drop", {31'h0, Done}, 32'h0);
    chk_state("mul_300_hold", 16'h5F90, 4'b0010);

    // Abort with Clear, then 7 * 6
    wr(2'd0, 1'b1, 3'd7, 11'h0, 16'd3);
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_busy_before", {31'h0, Busy}, 32'h1);
    Clear = 1'b1; #1;
    chk("abort_busy", {31'h0, Busy}, 32'h0);
    chk("abort_acc", {16'h0, In_Data}, 32'h0);
    #2 Clear = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (Done || Busy) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    wr(2'd1, 1'b0, 3'd0, 11'h007, 16'h0);
    wr(2'd0, 1'b1, 3'd7, 11'h0, 16'd6);
    cyc = 0;
    while (!Done && cyc < 60) begin @(posedge clk); #1; cyc++; end
    chk("mul2_done_seen", {31'h0, Done}, 32'h1);
    chk_state("mul_7x6", 16'd42, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
